// File: rtl/ds_adc_pkg.sv
// rtl/ds_adc_pkg.sv - shared types and helpers for the delta-sigma ADC scheduler
package ds_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } ds_sched_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ds_adc_rr_arb.sv
// rtl/ds_adc_rr_arb.sv - combinational round-robin arbiter with registered priority pointer
module ds_adc_rr_arb
    import ds_adc_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] req,
    input  logic           upd,
    input  logic [CW-1:0]  upd_idx,
    output logic [NCH-1:0] win_oh,
    output logic [CW-1:0]  win_idx
);

    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] scan_idx;
    logic          found;
    int            j;

    // ptr_q holds the highest-priority channel: one past the last granted
    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = (upd_idx == CW'(NCH - 1)) ? '0 : upd_idx + CW'(1);
        end
    end

    always_comb begin
        win_oh   = '0;
        win_idx  = '0;
        found    = 1'b0;
        j        = 0;
        scan_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            scan_idx = CW'(j);
            if (!found && req[scan_idx]) begin
                found             = 1'b1;
                win_oh[scan_idx]  = 1'b1;
                win_idx           = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ds_adc_scheduler.sv
// rtl/ds_adc_scheduler.sv - time-shares one delta-sigma ADC between NCH requesters
module ds_adc_scheduler
    import ds_adc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int SETTLE   = 3,
    parameter int AVG_LOG2 = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               enable,
    input  logic [NCH-1:0]                     req,
    input  logic                               sample_stb,
    input  logic signed [WIDTH-1:0]            adc_data,
    output logic [clog2_min1(NCH)-1:0]         ch_sel,
    output logic                               busy,
    output logic [NCH-1:0]                     gnt,
    output logic signed [WIDTH-1:0]            result,
    output logic [clog2_min1(NCH)-1:0]         result_ch
);

    localparam int CW   = clog2_min1(NCH);
    localparam int AW   = WIDTH + AVG_LOG2;
    localparam int NAVG = 1 << AVG_LOG2;
    localparam int CNTW = 5;

    ds_sched_state_t          state_q, state_d;
    logic [CW-1:0]            ch_sel_q, ch_sel_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic                     busy_q, busy_d;
    logic [NCH-1:0]           gnt_q, gnt_d;
    logic signed [WIDTH-1:0]  result_q, result_d;
    logic [CW-1:0]            result_ch_q, result_ch_d;

    logic signed [AW-1:0]     sample_ext;
    logic signed [AW-1:0]     acc_nxt;
    logic [NCH-1:0]           arb_oh;
    logic [CW-1:0]            arb_idx;
    logic                     ptr_upd;

    assign sample_ext = AW'(adc_data);
    assign acc_nxt    = acc_q + sample_ext;

    ds_adc_rr_arb #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .upd     (ptr_upd),
        .upd_idx (ch_sel_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        ch_sel_d    = ch_sel_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        gnt_d       = '0;
        result_d    = result_q;
        result_ch_d = result_ch_q;
        ptr_upd     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && (|arb_oh)) begin
                    ch_sel_d = arb_idx;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = ((arb_idx == ch_sel_q) || (SETTLE == 0)) ? ST_ACCUM : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (sample_stb) begin
                    if (cnt_q == CNTW'(SETTLE - 1)) begin
                        state_d = ST_ACCUM;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ST_ACCUM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (sample_stb) begin
                    acc_d = acc_nxt;
                    if (cnt_q == CNTW'(NAVG - 1)) begin
                        // grant and result are registered on the edge into DONE
                        state_d = ST_DONE;
                        if (req[ch_sel_q]) begin
                            gnt_d[ch_sel_q] = 1'b1;
                            result_d        = WIDTH'(acc_nxt >>> AVG_LOG2);
                            result_ch_d     = ch_sel_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_upd = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            ch_sel_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            gnt_q       <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_sel_q    <= ch_sel_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            gnt_q       <= gnt_d;
            result_q    <= result_d;
            result_ch_q <= result_ch_d;
        end
    end

    assign ch_sel    = ch_sel_q;
    assign busy      = busy_q;
    assign gnt       = gnt_q;
    assign result    = result_q;
    assign result_ch = result_ch_q;

endmodule
